// File: rtl/runlength_encoder.sv
// Zig-zag coefficient run-length encoder: turns 64-coefficient blocks into
// (run, amplitude) symbols with ZRL (15,0) escapes and an end-of-block marker.
module runlength_encoder #(
  parameter int AMPLITUDE_PRECISION = 16
) (
  input  logic                           i_sysclk,
  input  logic                           i_arst,
  input  logic                           i_we,
  input  logic [AMPLITUDE_PRECISION-1:0] i_B,
  output logic                           o_ready,
  output logic                           o_we,
  output logic                           o_eob,
  output logic [4:0]                     o_runlength,
  output logic [AMPLITUDE_PRECISION-1:0] o_B,
  input  logic                           i_ready
);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_ZRL     = 2'd1;
  localparam logic [1:0] S_LAST    = 2'd2;

  logic [1:0]                            state;
  logic [5:0]                            idx;
  logic [5:0]                            z;
  logic [1:0]                            zrl_cnt;
  logic                                  last_pend;
  logic [3:0]                            held_run;
  logic signed [AMPLITUDE_PRECISION-1:0] held_b;
  logic                                  out_we;
  logic                                  out_eob;
  logic [3:0]                            out_run;
  logic signed [AMPLITUDE_PRECISION-1:0] out_b;

  logic slot_free;
  logic accept;
  logic coef_zero;

  assign slot_free   = !out_we || i_ready;
  assign o_ready     = (state == S_COLLECT) && slot_free;
  assign accept      = i_we && o_ready;
  assign coef_zero   = (i_B == '0);

  assign o_we        = out_we;
  assign o_eob       = out_eob;
  assign o_runlength = {1'b0, out_run};
  assign o_B         = out_b;

  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      state     <= S_COLLECT;
      idx       <= '0;
      z         <= '0;
      zrl_cnt   <= '0;
      last_pend <= 1'b0;
      held_run  <= '0;
      held_b    <= '0;
      out_we    <= 1'b0;
      out_eob   <= 1'b0;
      out_run   <= '0;
      out_b     <= '0;
    end else begin
      // A consumed (or empty) slot goes invalid unless something loads it below.
      if (slot_free)
        out_we <= 1'b0;

      case (state)
        S_COLLECT: begin
          if (accept) begin
            idx <= idx + 6'd1;
            if (idx == 6'd0) begin
              held_run <= '0;
              held_b   <= i_B;
              z        <= '0;
            end else if (!coef_zero) begin
              out_we    <= 1'b1;
              out_eob   <= 1'b0;
              out_run   <= held_run;
              out_b     <= held_b;
              held_run  <= z[3:0];
              held_b    <= i_B;
              zrl_cnt   <= z[5:4];
              z         <= '0;
              last_pend <= (idx == 6'd63);
              if (z[5:4] != 2'd0)
                state <= S_ZRL;
              else if (idx == 6'd63)
                state <= S_LAST;
            end else if (idx == 6'd63) begin
              // Trailing zeros are implied by the end-of-block marker.
              out_we   <= 1'b1;
              out_eob  <= 1'b1;
              out_run  <= held_run;
              out_b    <= held_b;
              held_run <= '0;
              held_b   <= '0;
              z        <= '0;
            end else begin
              z <= z + 6'd1;
            end
          end
        end

        S_ZRL: begin
          if (slot_free) begin
            out_we  <= 1'b1;
            out_eob <= 1'b0;
            out_run <= 4'd15;
            out_b   <= '0;
            zrl_cnt <= zrl_cnt - 2'd1;
            if (zrl_cnt == 2'd1)
              state <= last_pend ? S_LAST : S_COLLECT;
          end
        end

        S_LAST: begin
          if (slot_free) begin
            out_we    <= 1'b1;
            out_eob   <= 1'b1;
            out_run   <= held_run;
            out_b     <= held_b;
            held_run  <= '0;
            held_b    <= '0;
            last_pend <= 1'b0;
            state     <= S_COLLECT;
          end
        end

        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: doc/runlength_encoder.md
RUNLENGTH_ENCODER -- requirements
Module: runlength_encoder

Interface
REQ-001 Parameter AMPLITUDE_PRECISION, default 16, is the coefficient/amplitude width in bits (two's complement).
REQ-002 i_sysclk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_arst  input  1  reset, asynchronous, active-high.
REQ-004 i_we  input  1  input coefficient valid.
REQ-005 i_B  input  AMPLITUDE_PRECISION  coefficient, zig-zag order, index 0 (DC) first, 64 per block.
REQ-006 o_ready  output  1  encoder accepts i_B this cycle when high.
REQ-007 o_we  output  1  output symbol valid.
REQ-008 o_eob  output  1  symbol is the last of its block.
REQ-009 o_runlength  output  5  zeros preceding o_B; values 0..15 only, bit 4 always 0.
REQ-010 o_B  output  AMPLITUDE_PRECISION  symbol amplitude.
REQ-011 i_ready  input  1  downstream consumes the symbol when o_we and i_ready are both high.

Function
REQ-012 Input transfer occurs on a cycle with i_we=1 and o_ready=1; no other input cycle has effect.
REQ-013 Output slot is free when o_we=0 or i_ready=1; a loaded symbol holds o_we/o_eob/o_runlength/o_B stable until consumed.
REQ-014 Internal state: 6-bit coefficient index idx, 6-bit zero counter z, held symbol register (run, B), 2-bit ZRL counter, FSM {S_COLLECT, S_ZRL, S_LAST}.
REQ-015 o_ready = (state==S_COLLECT) and output slot free; combinational.
REQ-016 Coefficient is zero iff all AMPLITUDE_PRECISION bits are 0; sign is irrelevant.
REQ-017 idx 0: held <= (0, i_B) regardless of value, z <= 0, no output.
REQ-018 idx 1..62, zero: z <= z+1, no output.
REQ-019 idx 1..63, nonzero: output loaded with (held.run, held.B, eob=0); held <= (z mod 16, i_B); ZRL counter <= z div 16; z <= 0; go S_ZRL if ZRL counter nonzero.
REQ-020 idx 63 nonzero: after any ZRLs, FSM enters S_LAST, which loads held with eob=1 when the slot is free, then returns to S_COLLECT.
REQ-021 idx 63 zero: output loaded with (held.run, held.B, eob=1); pending zeros are discarded (no trailing ZRLs ever emitted).
REQ-022 S_ZRL: each free slot loads (15, 0, eob=0) and decrements counter; at zero go S_COLLECT (or S_LAST if block end).
REQ-023 idx increments on each accepted coefficient, wraps 63->0; z, held cleared at wrap.
REQ-024 Latency: symbol loaded on the accepting edge appears with o_we=1 in the following cycle.
REQ-025 Symbol order per block: DC symbol first, ZRLs before the symbol they precede, exactly one eob=1 symbol last.
REQ-026 Output decodes back to the original 64 coefficients by inserting runlength zeros before each B and zero-padding after eob.

Reset
REQ-027 While i_arst=1: o_we=0, o_eob=0, o_runlength=0, o_B=0, idx=0, z=0, ZRL counter=0, FSM=S_COLLECT; o_ready=1 after release.
REQ-028 Reset mid-block discards all partial state; the first coefficient accepted afterwards is idx 0.

Verification
REQ-029 DC=0x0001, idx2=0x0002, rest 0, i_ready=1 -> (0,0x0001,eob0), (1,0x0002,eob1).
REQ-030 All 64 coefficients 0 -> single symbol (0,0x0000,eob1).
REQ-031 DC=0x0005, idx40=0x0007, rest 0 -> (0,5,0),(15,0,0),(15,0,0),(7,7,1); o_ready low during ZRLs.
REQ-032 DC=0x0003, idx63=0xFFF7, rest 0 -> (0,3,0),(15,0,0)x3,(14,0xFFF7,1).
REQ-033 Coefficients 1..64 all nonzero, i_ready toggling 1/0 -> 64 symbols runlength 0, B=1..64 in order, eob only on B=64, outputs stable while i_ready=0, no loss or duplication.
REQ-034 i_arst asserted after idx 10 of a block -> outputs 0 immediately; next block encodes correctly from idx 0.
